// File: rtl/rv32i_mc_core.sv
// Minimal multicycle RV32I-subset core: fetch, execute, word load/store over req/gnt/rvalid buses.
// Optional instret_o counter is built when CORE_INSTRET_EN is defined.
module rv32i_mc_core (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_enable_i,
    input  logic [31:0] boot_addr_i,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic        core_sleep_o
`ifdef CORE_INSTRET_EN
    ,
    output logic [31:0] instret_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_IWAIT = 3'd2,
        S_EXEC  = 3'd3,
        S_MREQ  = 3'd4,
        S_MWAIT = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JLR = 7'b1100111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    state_t      state_r, state_next_s;
    logic [31:0] pc_r, ir_r;
    logic [31:0] rf_r [0:31];
    logic        instr_req_r, data_req_r, data_we_r, core_sleep_r;
    logic [31:0] data_addr_r, data_wdata_r;

    logic [6:0]  opcode_s, funct7_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [31:0] rs1_val_s, rs2_val_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic        illegal_s, rd_we_s, is_mem_s, is_store_s;
    logic [31:0] rd_wdata_s, pc_target_s, pc_next_s, mem_addr_s;

    // Shared ALU for OP and OP-IMM; alt selects SUB/SRA.
    function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  alu_f = alt ? (a - b) : (a + b);
            3'b001:  alu_f = a << b[4:0];
            3'b010:  alu_f = {31'd0, ($signed(a) < $signed(b))};
            3'b100:  alu_f = a ^ b;
            3'b101:  alu_f = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'b110:  alu_f = a | b;
            3'b111:  alu_f = a & b;
            default: alu_f = 32'd0;
        endcase
    endfunction

    assign opcode_s  = ir_r[6:0];
    assign rd_s      = ir_r[11:7];
    assign funct3_s  = ir_r[14:12];
    assign rs1_s     = ir_r[19:15];
    assign rs2_s     = ir_r[24:20];
    assign funct7_s  = ir_r[31:25];
    assign rs1_val_s = (rs1_s == 5'd0) ? 32'd0 : rf_r[rs1_s];
    assign rs2_val_s = (rs2_s == 5'd0) ? 32'd0 : rf_r[rs2_s];
    assign imm_i_s   = {{20{ir_r[31]}}, ir_r[31:20]};
    assign imm_s_s   = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
    assign imm_b_s   = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
    assign imm_u_s   = {ir_r[31:12], 12'd0};
    assign imm_j_s   = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
    assign pc_next_s = pc_target_s & WORD_MASK;

    // Instruction decode and execute results for the EXEC cycle.
    always_comb begin
        illegal_s   = 1'b0;
        rd_we_s     = 1'b0;
        rd_wdata_s  = 32'd0;
        is_mem_s    = 1'b0;
        is_store_s  = 1'b0;
        mem_addr_s  = rs1_val_s + imm_i_s;
        pc_target_s = pc_r + 32'd4;
        case (opcode_s)
            OP_IMM: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = alu_f(funct3_s, (funct3_s == 3'b101) && ir_r[30], rs1_val_s, imm_i_s);
                if (funct3_s == 3'b011) begin
                    illegal_s = 1'b1;
                end else if (funct3_s == 3'b001) begin
                    illegal_s = (funct7_s != 7'b0000000);
                end else if (funct3_s == 3'b101) begin
                    illegal_s = (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000);
                end else begin
                    illegal_s = 1'b0;
                end
            end
            OP_REG: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = alu_f(funct3_s, ir_r[30], rs1_val_s, rs2_val_s);
                if (funct3_s == 3'b011) begin
                    illegal_s = 1'b1;
                end else if (funct7_s == 7'b0000000) begin
                    illegal_s = 1'b0;
                end else if (funct7_s == 7'b0100000) begin
                    illegal_s = (funct3_s != 3'b000) && (funct3_s != 3'b101);
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OP_LUI: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = imm_u_s;
            end
            OP_AUI: begin
                rd_we_s    = 1'b1;
                rd_wdata_s = pc_r + imm_u_s;
            end
            OP_JAL: begin
                rd_we_s     = 1'b1;
                rd_wdata_s  = pc_r + 32'd4;
                pc_target_s = pc_r + imm_j_s;
            end
            OP_JLR: begin
                rd_we_s     = 1'b1;
                rd_wdata_s  = pc_r + 32'd4;
                pc_target_s = (rs1_val_s + imm_i_s) & 32'hFFFF_FFFE;
                illegal_s   = (funct3_s != 3'b000);
            end
            OP_BR: begin
                case (funct3_s)
                    3'b000:  pc_target_s = (rs1_val_s == rs2_val_s) ? pc_r + imm_b_s : pc_r + 32'd4;
                    3'b001:  pc_target_s = (rs1_val_s != rs2_val_s) ? pc_r + imm_b_s : pc_r + 32'd4;
                    3'b100:  pc_target_s = ($signed(rs1_val_s) < $signed(rs2_val_s)) ? pc_r + imm_b_s : pc_r + 32'd4;
                    3'b101:  pc_target_s = ($signed(rs1_val_s) >= $signed(rs2_val_s)) ? pc_r + imm_b_s : pc_r + 32'd4;
                    default: illegal_s   = 1'b1;
                endcase
            end
            OP_LD: begin
                is_mem_s  = 1'b1;
                illegal_s = (funct3_s != 3'b010);
            end
            OP_ST: begin
                is_mem_s   = 1'b1;
                is_store_s = 1'b1;
                mem_addr_s = rs1_val_s + imm_s_s;
                illegal_s  = (funct3_s != 3'b010);
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Next-state logic for the fetch/execute/memory sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:  state_next_s = fetch_enable_i ? S_FETCH : S_IDLE;
            S_FETCH: state_next_s = instr_gnt_i ? S_IWAIT : S_FETCH;
            S_IWAIT: state_next_s = instr_rvalid_i ? S_EXEC : S_IWAIT;
            S_EXEC: begin
                if (illegal_s) begin
                    state_next_s = S_HALT;
                end else if (is_mem_s) begin
                    state_next_s = S_MREQ;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_MREQ:  state_next_s = data_gnt_i ? S_MWAIT : S_MREQ;
            S_MWAIT: state_next_s = data_rvalid_i ? S_FETCH : S_MWAIT;
            S_HALT:  state_next_s = S_HALT;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register; bus request and sleep flags are registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= S_IDLE;
            instr_req_r  <= 1'b0;
            data_req_r   <= 1'b0;
            core_sleep_r <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            instr_req_r  <= (state_next_s == S_FETCH);
            data_req_r   <= (state_next_s == S_MREQ);
            core_sleep_r <= (state_next_s == S_IDLE) || (state_next_s == S_HALT);
        end
    end

    // Architectural state: PC, IR, register file and data-bus holding registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_r         <= boot_addr_i & WORD_MASK;
            ir_r         <= 32'd0;
            data_addr_r  <= 32'd0;
            data_wdata_r <= 32'd0;
            data_we_r    <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else begin
            if ((state_r == S_IWAIT) && instr_rvalid_i) begin
                ir_r <= instr_rdata_i;
            end
            if ((state_r == S_EXEC) && !illegal_s) begin
                if (is_mem_s) begin
                    data_addr_r <= mem_addr_s & WORD_MASK;
                    data_we_r   <= is_store_s;
                    if (is_store_s) begin
                        data_wdata_r <= rs2_val_s;
                    end
                end else begin
                    pc_r <= pc_next_s;
                    if (rd_we_s && (rd_s != 5'd0)) begin
                        rf_r[rd_s] <= rd_wdata_s;
                    end
                end
            end
            if ((state_r == S_MWAIT) && data_rvalid_i) begin
                pc_r <= pc_r + 32'd4;
                if (!data_we_r && (rd_s != 5'd0)) begin
                    rf_r[rd_s] <= data_rdata_i;
                end
            end
        end
    end

`ifdef CORE_INSTRET_EN
    logic [31:0] instret_r;

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instret_r <= 32'd0;
        end else if (((state_r == S_EXEC) && !illegal_s && !is_mem_s) ||
                     ((state_r == S_MWAIT) && data_rvalid_i)) begin
            instret_r <= instret_r + 32'd1;
        end
    end

    assign instret_o = instret_r;
`endif

    assign instr_req_o  = instr_req_r;
    assign instr_addr_o = pc_r;
    assign data_req_o   = data_req_r;
    assign data_we_o    = data_we_r;
    assign data_be_o    = 4'b1111;
    assign data_addr_o  = data_addr_r;
    assign data_wdata_o = data_wdata_r;
    assign core_sleep_o = core_sleep_r;

endmodule

// File: tb/tb_rv32i_mc_core.sv
// Directed bench for rv32i_mc_core: fetch cadence, loads/stores, stalls, branches, HALT and reset.
module tb_rv32i_mc_core;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_enable_i = 1'b0;
    logic [31:0] boot_addr_i = 32'd0;
    logic        instr_req_o;
    logic        instr_gnt_i = 1'b1;
    logic        instr_rvalid_i = 1'b1;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_rdata_i = 32'd0;
    logic        data_req_o;
    logic        data_gnt_i = 1'b1;
    logic        data_rvalid_i = 1'b1;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i = 32'd0;
    logic        core_sleep_o;

    int checks = 0;
    int errors = 0;

    rv32i_mc_core dut (
        .clk_i(clk_i), .rst_i(rst_i), .fetch_enable_i(fetch_enable_i), .boot_addr_i(boot_addr_i),
        .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_addr_o(instr_addr_o), .instr_rdata_i(instr_rdata_i),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i), .core_sleep_o(core_sleep_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [31:0] boot, input logic fen);
        rst_i = 1'b1;
        boot_addr_i = boot;
        fetch_enable_i = fen;
        instr_gnt_i = 1'b1;
        data_gnt_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rst_ireq", {31'd0, instr_req_o}, 32'd0);
        check("rst_dreq", {31'd0, data_req_o}, 32'd0);
        check("rst_dwe", {31'd0, data_we_o}, 32'd0);
        check("rst_iaddr", instr_addr_o, boot & 32'hFFFF_FFFC);
        check("rst_daddr", data_addr_o, 32'd0);
        check("rst_wdata", data_wdata_o, 32'd0);
        check("rst_sleep", {31'd0, core_sleep_o}, 32'd1);
        rst_i = 1'b0;
    endtask

    // Wait for the next fetch request, check its address/spacing, then present the instruction.
    task automatic fetch(input logic [31:0] insn, input logic [31:0] exp_addr, input int exp_cyc);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!instr_req_o && cyc < 20);
        check("ireq", {31'd0, instr_req_o}, 32'd1);
        check("iaddr", instr_addr_o, exp_addr);
        if (exp_cyc > 0) check("icycles", cyc, exp_cyc);
        instr_rdata_i = insn;
    endtask

    task automatic mem_chk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!data_req_o && cyc < 20);
        check("dreq", {31'd0, data_req_o}, 32'd1);
        check("dcycles", cyc, 32'd3);
        check("dwe", {31'd0, data_we_o}, {31'd0, we});
        check("dbe", {28'd0, data_be_o}, 32'hF);
        check("daddr", data_addr_o, addr);
        if (we) check("dwdata", data_wdata_o, wdata);
    endtask

    task automatic halt_chk(input logic [31:0] held_addr);
        repeat (3) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            check("halt_sleep", {31'd0, core_sleep_o}, 32'd1);
            check("halt_ireq", {31'd0, instr_req_o}, 32'd0);
            check("halt_dreq", {31'd0, data_req_o}, 32'd0);
            @(negedge clk_i);
        end
        check("halt_daddr_hold", data_addr_o, held_addr);
    endtask

    initial begin
        // Phase 1: addi stream, sw/lw/sw, fetch stall, branch, HALT.
        instr_rdata_i = 32'h0015_0513;
        do_reset(32'h0000_0080, 1'b1);
        fetch(32'h0015_0513, 32'h80, -1);
        fetch(32'h0015_0513, 32'h84, 3);
        fetch(32'h0015_0513, 32'h88, 3);
        fetch(32'h0015_0513, 32'h8C, 3);
        fetch(32'h0015_0513, 32'h90, 3);
        fetch(32'h00A0_2023, 32'h94, 3);
        mem_chk(1'b1, 32'h0, 32'h5);
        data_rdata_i = 32'hDEAD_BEEF;
        fetch(32'h0000_2583, 32'h98, 2);
        mem_chk(1'b0, 32'h0, 32'h0);
        data_gnt_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            check("dstall_req", {31'd0, data_req_o}, 32'd1);
            check("dstall_addr", data_addr_o, 32'h0);
        end
        data_gnt_i = 1'b1;
        fetch(32'h00B0_2223, 32'h9C, 2);
        mem_chk(1'b1, 32'h4, 32'hDEAD_BEEF);
        fetch(32'h0000_0463, 32'hA0, 2);
        instr_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("istall_req", {31'd0, instr_req_o}, 32'd1);
            check("istall_addr", instr_addr_o, 32'hA0);
        end
        instr_gnt_i = 1'b1;
        fetch(32'hFFFF_FFFF, 32'hA8, 3);
        halt_chk(32'h4);

        // Phase 2: ALU/branch/jump program from a misaligned boot address.
        do_reset(32'h0000_0083, 1'b1);
        fetch(32'h0000_0463, 32'h80, -1);
        fetch(32'h8000_00B7, 32'h88, 3);
        fetch(32'h4040_D113, 32'h8C, 3);
        fetch(32'h0020_2023, 32'h90, 3);
        mem_chk(1'b1, 32'h0, 32'hF800_0000);
        fetch(32'hFFD0_0193, 32'h94, 2);
        fetch(32'h4011_8233, 32'h98, 3);
        fetch(32'h0040_2223, 32'h9C, 3);
        mem_chk(1'b1, 32'h4, 32'h7FFF_FFFD);
        fetch(32'h0001_A2B3, 32'hA0, 2);
        fetch(32'h0050_2423, 32'hA4, 3);
        mem_chk(1'b1, 32'h8, 32'h1);
        fetch(32'h0080_036F, 32'hA8, 2);
        fetch(32'h0060_24A3, 32'hB0, 3);
        mem_chk(1'b1, 32'h8, 32'hAC);
        fetch(32'hFFFF_FFFF, 32'hB4, 2);
        halt_chk(32'h8);

        // Phase 3: fetch_enable gating in IDLE, then reset in the middle of MREQ.
        do_reset(32'h0000_0100, 1'b0);
        repeat (3) @(negedge clk_i);
        check("idle_ireq", {31'd0, instr_req_o}, 32'd0);
        check("idle_sleep", {31'd0, core_sleep_o}, 32'd1);
        fetch_enable_i = 1'b1;
        fetch(32'h0000_2023, 32'h100, -1);
        mem_chk(1'b1, 32'h0, 32'h0);
        data_gnt_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("mrst_dreq", {31'd0, data_req_o}, 32'd0);
        check("mrst_ireq", {31'd0, instr_req_o}, 32'd0);
        check("mrst_sleep", {31'd0, core_sleep_o}, 32'd1);
        check("mrst_pc", instr_addr_o, 32'h100);
        rst_i = 1'b0;
        data_gnt_i = 1'b1;
        @(negedge clk_i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
